led_shift_driver: RTL and testbench
===================================

Name: led_shift_driver

Overview:
- Serial transmitter for the 8-bit LED bus produced by the switch/LED logic block.
- Captures the parallel led word and shifts it MSB-first into an external 74HC595-style shift/latch register (serial data, shift clock, storage latch).
- Sits between the led output of the core and the board pins.
- Refreshes continuously while enabled.

Parameters:
- WIDTH, 8, number of LED bits per frame (>=1).
- CLK_DIV, 2, clk cycles per half-period of sr_clk, and the sr_latch pulse length (>=1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- enable  input  1  1 = start a new frame whenever IDLE; 0 = stop after the current frame.
- led  input  WIDTH  parallel LED word; sampled only at frame start.
- sr_clk  output  1  shift clock to the external register; data is shifted on its rising edge.
- sr_data  output  1  serial data, MSB first.
- sr_latch  output  1  storage-register latch pulse.
- busy  output  1  high while a frame is in progress.
- frame_done  output  1  one-cycle pulse after each completed frame.

Behaviour:
- Reset and clocking
  - One clock, clk.
  - Reset rst is asynchronous, active-low.
  - While rst=0: state IDLE; sr_clk, sr_data, sr_latch, busy and frame_done are all 0; shift register and counters are 0.
- Registered outputs
  - All outputs are registered; there are no combinational paths from inputs to outputs.
- State machine: IDLE -> SHIFT -> LATCH -> IDLE.
- IDLE
  - sr_clk=0, sr_data=0, sr_latch=0, busy=0.
  - On a clk edge with enable=1:
    - shreg <= led; sr_data <= led[WIDTH-1]; busy <= 1.
    - bit counter <= 0; divider <= 0; go to SHIFT.
- SHIFT, per bit
  - sr_clk is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - sr_data is stable for the whole 2*CLK_DIV-cycle bit window.
  - At the end of the high phase, sr_clk returns to 0 and sr_data advances to the next lower bit.
  - After bit 0's high phase: sr_clk <= 0, sr_data <= 0, sr_latch <= 1; go to LATCH.
- LATCH
  - sr_latch is held high for CLK_DIV cycles.
  - Then: sr_latch <= 0, busy <= 0, frame_done <= 1; go to IDLE.
- frame_done
  - High for exactly the first IDLE cycle after a frame; otherwise 0.
- Frame timing
  - Frame period with enable held at 1 is WIDTH*2*CLK_DIV + CLK_DIV + 1 clk cycles.
  - This is 35 cycles at the defaults.
  - The next capture happens on the edge that ends the frame_done cycle.
- busy
  - High from the cycle after capture through the last LATCH cycle: WIDTH*2*CLK_DIV + CLK_DIV cycles.
- led changing mid-frame
  - Ignored; the frame transmits the word captured at start.
- enable falling mid-frame
  - The current frame completes unchanged, including the latch and frame_done.
  - The block then remains IDLE.
- enable=0 in the frame_done cycle
  - No new capture.
- rst asserted mid-frame
  - All outputs go to 0 immediately (asynchronously); no latch pulse is produced.
  - After release, the block starts from IDLE.
- Exactly WIDTH rising edges of sr_clk occur per frame.
  - sr_latch never overlaps sr_clk=1.
- Counter widths
  - Bit counter: clog2(WIDTH) bits (minimum 1).
  - Divider: clog2(CLK_DIV) bits (minimum 1).
  - Counters wrap to 0 at their terminal counts, never beyond.

Test Plan:
- Reset then enable=1, led=8'hA5, defaults:
  - sr_data sampled at the 8 sr_clk rising edges = 1,0,1,0,0,1,0,1.
  - sr_latch high 2 cycles; frame_done pulses at cycle 35.
- enable held 1, led=8'h3C constant:
  - Back-to-back frames every 35 cycles.
  - frame_done period 35; busy low exactly 1 cycle between frames.
- Start a frame with led=8'hFF, change led to 8'h00 at cycle 5:
  - Frame shifts 8 ones.
  - The next frame shifts 8 zeros.
- enable dropped at cycle 10 of a frame with led=8'h81:
  - Frame completes (bits 1,0,0,0,0,0,0,1, latch, frame_done).
  - Afterwards busy=0 and sr_clk stays 0 indefinitely.
- rst pulled low during the 4th bit:
  - Same cycle: all outputs 0, no sr_latch.
  - After release with enable=1: a full fresh frame of the current led value.
- CLK_DIV=1, WIDTH=4, led=4'b1001:
  - sr_clk toggles every cycle; bits 1,0,0,1.
  - Latch 1 cycle; frame period 4*2+1+1 = 10 cycles.

Source files
------------

// File: rtl/led_shift_driver.sv
// led_shift_driver: serialises a parallel LED word MSB-first into a 74HC595-style
// shift/latch register, refreshing continuously while enabled.
module led_shift_driver #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] led,
    output logic             sr_clk,
    output logic             sr_data,
    output logic             sr_latch,
    output logic             busy,
    output logic             frame_done
);
    localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [DW-1:0]    div_q, div_d;
    logic             sr_clk_q, sr_clk_d;
    logic             sr_data_q, sr_data_d;
    logic             sr_latch_q, sr_latch_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;

    assign sr_clk     = sr_clk_q;
    assign sr_data    = sr_data_q;
    assign sr_latch   = sr_latch_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_d        = bit_q;
        div_d        = div_q;
        sr_clk_d     = sr_clk_q;
        sr_data_d    = sr_data_q;
        sr_latch_d   = sr_latch_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    shreg_d   = led;
                    sr_data_d = led[WIDTH-1];
                    busy_d    = 1'b1;
                    bit_d     = '0;
                    div_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d    = '0;
                    sr_clk_d = !sr_clk_q;
                    // End of the high phase: either move to the next bit or finish the frame
                    if (sr_clk_q) begin
                        if (bit_q == BIT_LAST) begin
                            bit_d      = '0;
                            sr_data_d  = 1'b0;
                            sr_latch_d = 1'b1;
                            state_d    = LATCH;
                        end else begin
                            bit_d     = bit_q + 1'b1;
                            shreg_d   = shreg_q << 1;
                            sr_data_d = shreg_d[WIDTH-1];
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            LATCH: begin
                if (div_q == DIV_LAST) begin
                    div_d        = '0;
                    sr_latch_d   = 1'b0;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_q        <= '0;
            div_q        <= '0;
            sr_clk_q     <= 1'b0;
            sr_data_q    <= 1'b0;
            sr_latch_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_q        <= bit_d;
            div_q        <= div_d;
            sr_clk_q     <= sr_clk_d;
            sr_data_q    <= sr_data_d;
            sr_latch_q   <= sr_latch_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_led_shift_driver.sv
// tb_led_shift_driver: drives a default (8-bit, div 2) and a small (4-bit, div 1)
// instance and checks every cycle against a frame-position reference model.
module tb_led_shift_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en1 = 1'b0, en2 = 1'b0;
    logic [7:0] led1 = '0;
    logic [3:0] led2 = '0;
    logic       c1, d1, l1, b1, f1;
    logic       c2, d2, l2, b2, f2;
    int         checks = 0, errors = 0;

    // Model: t = cycles since capture (0 = idle), fd = frame_done expected, w = captured word
    int         t1 = 0, t2 = 0;
    bit         fd1 = 0, fd2 = 0;
    logic [7:0] w1 = '0, w2 = '0;
    localparam int P1 = 8 * 2 * 2 + 2 + 1;
    localparam int P2 = 4 * 2 * 1 + 1 + 1;

    always #5 clk = ~clk;

    led_shift_driver #(.WIDTH(8), .CLK_DIV(2)) dut1 (
        .clk(clk), .rst(rst), .enable(en1), .led(led1),
        .sr_clk(c1), .sr_data(d1), .sr_latch(l1), .busy(b1), .frame_done(f1));

    led_shift_driver #(.WIDTH(4), .CLK_DIV(1)) dut2 (
        .clk(clk), .rst(rst), .enable(en2), .led(led2),
        .sr_clk(c2), .sr_data(d2), .sr_latch(l2), .busy(b2), .frame_done(f2));

    // Expected {sr_clk, sr_data, sr_latch, busy, frame_done} at frame position t
    function automatic logic [4:0] expv(int t, bit fd, logic [7:0] w, int W, int CD);
        int p;
        p = t - 1;
        if (t == 0) return {4'b0000, fd};
        if (t <= W * 2 * CD) return {(p % (2 * CD)) >= CD, w[W - 1 - p / (2 * CD)], 3'b010};
        return 5'b00110;
    endfunction

    task automatic step_model(inout int t, inout bit fd, inout logic [7:0] w,
                              input bit en, input logic [7:0] l, input int P);
        if (!rst) begin
            t = 0; fd = 0;
        end else if (t == 0) begin
            fd = 0;
            if (en) begin w = l; t = 1; end
        end else if (t == P - 1) begin
            t = 0; fd = 1;
        end else begin
            t++;
        end
    endtask

    task automatic check(string tag);
        checks++;
        assert ({c1, d1, l1, b1, f1} === expv(t1, fd1, w1, 8, 2)) else begin
            errors++;
            $error("FAIL %s w8 t=%0d got %b exp %b", tag, t1, {c1, d1, l1, b1, f1}, expv(t1, fd1, w1, 8, 2));
        end
        checks++;
        assert ({c2, d2, l2, b2, f2} === expv(t2, fd2, w2, 4, 1)) else begin
            errors++;
            $error("FAIL %s w4 t=%0d got %b exp %b", tag, t2, {c2, d2, l2, b2, f2}, expv(t2, fd2, w2, 4, 1));
        end
    endtask

    task automatic cyc(string tag);
        @(posedge clk);
        step_model(t1, fd1, w1, en1, led1, P1);
        step_model(t2, fd2, w2, en2, {4'b0000, led2}, P2);
        @(negedge clk);
        check(tag);
    endtask

    task automatic async_rst(string tag);
        #2 rst = 1'b0;
        #1;
        checks++;
        assert ({c1, d1, l1, b1, f1, c2, d2, l2, b2, f2} === 10'b0) else begin
            errors++;
            $error("FAIL %s async got %b exp 0", tag, {c1, d1, l1, b1, f1, c2, d2, l2, b2, f2});
        end
        t1 = 0; fd1 = 0; t2 = 0; fd2 = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int n, n1, n2;
        repeat (3) cyc("reset");
        rst = 1'b1;
        cyc("idle");
        // First frame: A5 / 1001 and latency to frame_done
        en1 = 1'b1; led1 = 8'hA5; en2 = 1'b1; led2 = 4'b1001;
        n1 = 0; n2 = 0;
        for (n = 1; n <= 40 && n1 == 0; n++) begin
            cyc("first");
            if (f1 && n1 == 0) n1 = n;
            if (f2 && n2 == 0) n2 = n;
        end
        checks++;
        assert (n1 == 35) else begin errors++; $error("FAIL latency8 got %0d exp 35", n1); end
        checks++;
        assert (n2 == 10) else begin errors++; $error("FAIL latency4 got %0d exp 10", n2); end
        // Back-to-back frames with a constant word
        led1 = 8'h3C;
        repeat (75) cyc("b2b");
        // led changes mid-frame are ignored
        while (t1 != 0) cyc("align");
        led1 = 8'hFF;
        repeat (5) cyc("ff");
        led1 = 8'h00; led2 = 4'b0110;
        repeat (70) cyc("ff00");
        // enable dropped partway into a frame
        while (t1 != 0) cyc("align2");
        led1 = 8'h81;
        repeat (10) cyc("drop");
        en1 = 1'b0; en2 = 1'b0;
        repeat (80) cyc("stopped");
        // async reset during the 4th bit
        en1 = 1'b1; en2 = 1'b1;
        for (n = 0; n < 40 && t1 != 14; n++) cyc("to_bit3");
        checks++;
        assert (t1 == 14) else begin errors++; $error("FAIL reach_bit3 got %0d exp 14", t1); end
        async_rst("mid");
        repeat (40) cyc("fresh");
        // Randomized stress
        for (int i = 0; i < 1500; i++) begin
            en1 = ($urandom_range(0, 7) != 0);
            en2 = ($urandom_range(0, 5) != 0);
            led1 = 8'($urandom);
            led2 = 4'($urandom);
            if ($urandom_range(0, 299) == 0) async_rst("rnd");
            cyc("rand");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
